// File: rtl/interrupt_queue.sv
// Pending-interrupt FIFO between interrupt sources (software INT, arbitrated hardware)
// and the DCPU-16 core. State advances on the falling edge of CORE_CLK, like the core.
module interrupt_queue #(
  parameter int DEPTH = 256,
  parameter int MSG_W = 16,
  parameter int CW    = 9
) (
  input  logic             CORE_CLK,
  input  logic             RESET_N,
  input  logic             SW_INT_push,
  input  logic [MSG_W-1:0] SW_INT_msg,
  input  logic             HW_INT_push,
  input  logic [MSG_W-1:0] HW_INT_msg,
  input  logic [15:0]      IA,
  input  logic             IAQ_en,
  input  logic             boundary,
  input  logic             int_take,
  output logic             int_valid,
  output logic [MSG_W-1:0] int_msg,
  output logic [CW-1:0]    q_count,
  output logic             q_empty,
  output logic             q_full,
  output logic             on_fire,
  output logic [1:0]       fsm_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, OFFER = 2'd1, DRAIN = 2'd2, FIRE = 2'd3} state_t;

  state_t           state, state_nxt;
  logic [MSG_W-1:0] mem [DEPTH];
  logic [AW-1:0]    rptr, wptr;
  logic [CW-1:0]    count;
  logic             fire;
  logic [MSG_W-1:0] msg_r;

  logic             ia_ok, sw_acc, hw_acc, pop, overflow, load_msg;
  logic [1:0]       n_acc;
  logic [CW:0]      count_sum;

  always_comb begin
    ia_ok     = (IA != 16'h0000);
    sw_acc    = SW_INT_push && ia_ok && !fire;
    hw_acc    = HW_INT_push && ia_ok && !fire;
    n_acc     = {1'b0, sw_acc} + {1'b0, hw_acc};
    state_nxt = state;
    pop       = 1'b0;
    load_msg  = 1'b0;
    case (state)
      IDLE: begin
        if (!IAQ_en && count != '0) begin
          if (!ia_ok) begin
            state_nxt = DRAIN;
          end else if (boundary) begin
            state_nxt = OFFER;
            load_msg  = 1'b1;
          end
        end
      end
      // Offer handshake: int_valid stays high with a stable int_msg until the core
      // raises int_take (pop on that edge) or the offer is withdrawn; int_take is
      // meaningless while int_valid is low.
      OFFER: begin
        if (int_take) begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end else if (IAQ_en || !boundary || !ia_ok) begin
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        if (!ia_ok && !IAQ_en && count != '0) pop = 1'b1;
        else state_nxt = IDLE;
      end
      FIRE:    state_nxt = FIRE;
      default: state_nxt = IDLE;
    endcase
    count_sum = {1'b0, count} + (CW+1)'(n_acc) - (CW+1)'(pop);
    overflow  = (count_sum > DEPTH_W);
    // Overflow freezes the queue exactly as it was; nothing is written or popped.
    if (overflow) begin
      state_nxt = FIRE;
      pop       = 1'b0;
      load_msg  = 1'b0;
    end
  end

  always_ff @(negedge CORE_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      fire  <= 1'b0;
      msg_r <= '0;
    end else begin
      state <= state_nxt;
      if (overflow) begin
        fire <= 1'b1;
      end else begin
        count <= count_sum[CW-1:0];
        wptr  <= wptr + AW'(n_acc);
        rptr  <= rptr + AW'(pop);
      end
      if (load_msg) msg_r <= mem[rptr];
    end
  end

  // Storage has no reset; SW lands in the first free slot, HW right after it.
  always_ff @(negedge CORE_CLK) begin
    if (!overflow) begin
      if (sw_acc) mem[wptr] <= SW_INT_msg;
      if (hw_acc) mem[sw_acc ? wptr + AW'(1) : wptr] <= HW_INT_msg;
    end
  end

  assign int_valid = (state == OFFER);
  assign int_msg   = msg_r;
  assign q_count   = count;
  assign q_empty   = (count == '0);
  assign q_full    = (count == DEPTH_C);
  assign on_fire   = fire;
  assign fsm_state = state;

endmodule

// File: doc/interrupt_queue.md
Name: interrupt_queue

Overview:
- Holds pending DCPU-16 interrupt messages between their sources and the CPU core.
- Sources: software INT issued by the core, and hardware device interrupts.
- The core takes one entry per instruction boundary when IA != 0 and queueing is off.
- Implements the spec'd 256-entry queue, including drop-on-IA=0 and the overflow "catch fire" halt condition.

Parameters:
DEPTH, 256, number of queued messages (power of two, >= 2)
MSG_W, 16, message width in bits
CW, 9, occupancy counter width (log2(DEPTH)+1)

Ports:
CORE_CLK  input  1  core clock; all state updates on the falling edge, the same edge as the CPU core
RESET_N  input  1  asynchronous active-low reset
SW_INT_push  input  1  one-cycle strobe: software INT from core
SW_INT_msg  input  MSG_W  message for SW_INT_push
HW_INT_push  input  1  one-cycle strobe: hardware interrupt (already arbitrated among devices)
HW_INT_msg  input  MSG_W  message for HW_INT_push
IA  input  16  core interrupt address register
IAQ_en  input  1  core queueing flag (IAQ set or handler running)
boundary  input  1  core is between instructions (fetch about to start)
int_take  input  1  core accepts the offered interrupt this cycle
int_valid  output  1  interrupt offered to core
int_msg  output  MSG_W  offered message (head of queue)
q_count  output  CW  current occupancy
q_empty  output  1  q_count == 0
q_full  output  1  q_count == DEPTH
on_fire  output  1  sticky overflow flag; core halts while high

Behaviour:
- Reset (RESET_N low, async): state=IDLE, read/write pointers=0, q_count=0, int_valid=0, int_msg=0, on_fire=0, q_empty=1, q_full=0. Storage contents are don't-care.
- Storage: circular buffer DEPTH x MSG_W. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Push rules, per edge:
  - pushes = SW_INT_push + HW_INT_push (0..2).
  - Both asserted: SW entry written first, HW second (consecutive slots).
  - A push with IA == 0 is silently dropped and is not counted.
  - A push while on_fire == 1 is ignored.
- Pop occurs on an edge when (state==OFFER and int_take) or state==DRAIN.
- Occupancy: q_count_next = q_count + pushes_accepted - pop.
- Overflow: if q_count + pushes_accepted - pop > DEPTH, then:
  - on_fire <= 1; offending pushes are not written.
  - state <= FIRE; pointers and count are frozen.
  - Any excess counts as overflow, including one of two simultaneous pushes at q_count == DEPTH-1 with no pop.
- FSM:
  - IDLE:
    - boundary and !IAQ_en and !q_empty and IA != 0 -> OFFER; int_valid<=1, int_msg<=head.
    - !IAQ_en and !q_empty and IA == 0 -> DRAIN.
  - OFFER: int_valid=1, int_msg held stable.
    - int_take -> pop, int_valid<=0, IDLE.
    - Otherwise, if IAQ_en rises, boundary falls, or IA becomes 0 -> int_valid<=0, IDLE, no pop.
  - DRAIN: pop and discard one entry per cycle while IA == 0 and !IAQ_en and !q_empty. Exit to IDLE otherwise.
  - FIRE: int_valid=0. Only reset leaves FIRE.
- Latency:
  - A push on edge N is visible in q_count after edge N.
  - With empty queue and conditions met, earliest int_valid is after edge N+1.
  - At most one entry is offered per boundary.
- int_take while int_valid == 0 is ignored (no pop).
- Simultaneous push and pop at q_count == DEPTH is legal: q_count stays DEPTH, no overflow.
- Reset mid-OFFER drops the offer; int_valid is low immediately (async).

Test Plan:
- Single SW push msg 0x1234, IA=0x0100, IAQ_en=0, boundary=1, int_take on first int_valid -> int_valid high after 2nd edge, int_msg=0x1234, q_count 1->0, returns to IDLE.
- SW 0xAAAA and HW 0x5555 in same cycle with IAQ_en=1, then IAQ_en=0 with boundary -> offers 0xAAAA first, then 0x5555 on the next boundary; q_count 2->1->0.
- Fill 256 entries with IAQ_en=1, then one more push -> on_fire=1 and stays 1, q_count=256, int_valid=0, further pushes ignored until RESET_N pulse clears all outputs.
- 3 entries queued with IAQ_en=1, then IA set to 0 and IAQ_en=0 -> DRAIN removes one per cycle, q_count 3->0 in 3 cycles, int_valid never high; a push with IA=0 leaves q_count=0.
- OFFER active, IAQ_en asserted before int_take -> int_valid drops, q_count unchanged, same message re-offered after IAQ_en clears.
- Wrap-around: 300 push/take pairs with incrementing messages -> messages delivered in order across pointer wrap, q_full never set.
